// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator (pixel enable, syncs, blank, coordinates)
//
// Purpose:
//   Divides the system clock down to a pixel rate and walks a raster of
//   H_TOTAL x V_TOTAL pixels. All outputs are registered. Sync, blank and
//   the start pulses are computed from the *next* counter values, so that
//   every output always describes the same pixel as DrawX/DrawY.
//
// Ports:
//   Clk          in   system clock, rising edge
//   Reset_n      in   asynchronous active-low reset
//   VGA_CLK      out  pixel clock to the DAC (falls on data change, rises mid-pixel)
//   pixel_tick   out  one-Clk pulse in the cycle that ends with a counter advance
//   VGA_HS       out  horizontal sync, asserted level SYNC_POL
//   VGA_VS       out  vertical sync, asserted level SYNC_POL
//   VGA_BLANK_N  out  1 while (DrawX,DrawY) is inside the visible area
//   VGA_SYNC_N   out  tied 0 (no sync-on-green)
//   DrawX        out  current horizontal count, 0..H_TOTAL-1
//   DrawY        out  current vertical count, 0..V_TOTAL-1
//   line_start   out  one-Clk pulse after DrawX is loaded with 0
//   frame_start  out  one-Clk pulse after (DrawX,DrawY) is loaded with (0,0)

module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic       Clk,
    input  logic       Reset_n,
    output logic       VGA_CLK,
    output logic       pixel_tick,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       line_start,
    output logic       frame_start
);

    // ------------------------------------------------------------------
    // Derived geometry
    // ------------------------------------------------------------------
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Guard against CLK_DIV < 2 so the counter width stays legal while the
    // elaboration check below reports the real problem.
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Region bounds are 11 bits wide: a sync window may end exactly at 1024.
    localparam logic [10:0] H_VIS_END    = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END    = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYNC_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (H_TOTAL > 1024) begin : g_err_h_total
        $error("vga_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_err_v_total
        $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end
    if (CLK_DIV < 2) begin : g_err_div_small
        $error("vga_timing_gen: CLK_DIV must be >= 2");
    end
    if ((CLK_DIV % 2) != 0) begin : g_err_div_odd
        $error("vga_timing_gen: CLK_DIV must be even");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_vga_clk;
    logic             r_pixel_tick;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic             r_hs;
    logic             r_vs;
    logic             r_blank_n;
    logic             r_line_start;
    logic             r_frame_start;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] w_div_next;
    logic             w_tick;
    logic [9:0]       w_x_next;
    logic [9:0]       w_y_next;
    logic [10:0]      w_x_ext;
    logic [10:0]      w_y_ext;
    logic             w_hs_act;
    logic             w_vs_act;
    logic             w_visible;

    always_comb begin
        w_tick     = (r_div_cnt == DIV_LAST);
        w_div_next = w_tick ? '0 : r_div_cnt + 1'b1;
    end

    // Raster advance: DrawY only moves on the tick where DrawX wraps, and
    // wraps itself on that same tick at the bottom of the frame.
    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_tick) begin
            if (r_x == H_LAST) begin
                w_x_next = '0;
                w_y_next = (r_y == V_LAST) ? '0 : r_y + 10'd1;
            end else begin
                w_x_next = r_x + 10'd1;
            end
        end
    end

    // Region decode on the pixel that is about to be displayed.
    always_comb begin
        w_x_ext   = {1'b0, w_x_next};
        w_y_ext   = {1'b0, w_y_next};
        w_hs_act  = (w_x_ext >= H_SYNC_START) && (w_x_ext < H_SYNC_END);
        w_vs_act  = (w_y_ext >= V_SYNC_START) && (w_y_ext < V_SYNC_END);
        w_visible = (w_x_ext < H_VIS_END) && (w_y_ext < V_VIS_END);
    end

    // ------------------------------------------------------------------
    // Divider, pixel clock and tick
    // ------------------------------------------------------------------
    // VGA_CLK and pixel_tick are registered from the next divider value so
    // they line up with the divider phase of the current cycle: VGA_CLK goes
    // low in the same edge that loads new pixel data and high halfway
    // through the pixel.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_div_cnt    <= '0;
            r_vga_clk    <= 1'b0;
            r_pixel_tick <= 1'b0;
        end else begin
            r_div_cnt    <= w_div_next;
            r_vga_clk    <= (w_div_next >= DIV_HALF);
            r_pixel_tick <= (w_div_next == DIV_LAST);
        end
    end

    // ------------------------------------------------------------------
    // Coordinates, syncs and blank (update only on the tick edge)
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_x       <= '0;
            r_y       <= '0;
            r_hs      <= ~SYNC_POL;
            r_vs      <= ~SYNC_POL;
            r_blank_n <= 1'b1;
        end else if (w_tick) begin
            r_x       <= w_x_next;
            r_y       <= w_y_next;
            r_hs      <= w_hs_act ? SYNC_POL : ~SYNC_POL;
            r_vs      <= w_vs_act ? SYNC_POL : ~SYNC_POL;
            r_blank_n <= w_visible;
        end
    end

    // ------------------------------------------------------------------
    // Start pulses
    // ------------------------------------------------------------------
    // Pulses are only raised by a tick that loads the origin, so the (0,0)
    // entered through reset never produces a spurious start.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= w_tick && (w_x_next == '0);
            r_frame_start <= w_tick && (w_x_next == '0) && (w_y_next == '0);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign VGA_CLK     = r_vga_clk;
    assign pixel_tick  = r_pixel_tick;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_SYNC_N  = 1'b0;
    assign DrawX       = r_x;
    assign DrawY       = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen

module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // Default 640x480 instance
    logic       d_vclk, d_tick, d_hs, d_vs, d_blank, d_syncn, d_line, d_frame;
    logic [9:0] d_x, d_y;

    // Small raster: H 8/2/3/2 = 15, V 4/1/2/1 = 8, CLK_DIV 4, active-high sync
    logic       s_vclk, s_tick, s_hs, s_vs, s_blank, s_syncn, s_line, s_frame;
    logic [9:0] s_x, s_y;

    vga_timing_gen u_dut (
        .Clk         (clk),
        .Reset_n     (rst_n),
        .VGA_CLK     (d_vclk),
        .pixel_tick  (d_tick),
        .VGA_HS      (d_hs),
        .VGA_VS      (d_vs),
        .VGA_BLANK_N (d_blank),
        .VGA_SYNC_N  (d_syncn),
        .DrawX       (d_x),
        .DrawY       (d_y),
        .line_start  (d_line),
        .frame_start (d_frame)
    );

    vga_timing_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
        .CLK_DIV   (4), .SYNC_POL (1'b1)
    ) u_small (
        .Clk         (clk),
        .Reset_n     (rst_n),
        .VGA_CLK     (s_vclk),
        .pixel_tick  (s_tick),
        .VGA_HS      (s_hs),
        .VGA_VS      (s_vs),
        .VGA_BLANK_N (s_blank),
        .VGA_SYNC_N  (s_syncn),
        .DrawX       (s_x),
        .DrawY       (s_y),
        .line_start  (s_line),
        .frame_start (s_frame)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Line / phase bookkeeping (default instance)
    int cx, cy, px, pvclk, phs, pblank;
    int step_err, phase_err, max_x, hs_low, hs_fall_x, hs_rise_x, blank_fall_x;
    int line_cnt, last_line, line_gap, vclk_hi;
    // Frame bookkeeping (small instance)
    int sx, sy, spx, spy, spblank, spvclk, spframe;
    int exp_hs, exp_vs, exp_blank, exp_x, exp_y;
    int dec_err, s_step_err, rng_err, wrap_err, s_phase_err, fcnt, last_f, gap_f;
    int vs_acc, vs_between, s_vclk_hi;
    int found, fs_early, fs_late, first_line;

    initial begin
        // ---------------- T1: reset values ----------------
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_x",      32'(d_x), 0);
        check("rst_y",      32'(d_y), 0);
        check("rst_vclk",   32'(d_vclk), 0);
        check("rst_tick",   32'(d_tick), 0);
        check("rst_hs",     32'(d_hs), 1);
        check("rst_vs",     32'(d_vs), 1);
        check("rst_blank",  32'(d_blank), 1);
        check("rst_syncn",  32'(d_syncn), 0);
        check("rst_line",   32'(d_line), 0);
        check("rst_frame",  32'(d_frame), 0);
        check("rst_s_hs",   32'(s_hs), 0);
        check("rst_s_vs",   32'(s_vs), 0);

        rst_n = 1'b1;
        @(negedge clk);                           // after edge 1
        check("t1_tick_e1", 32'(d_tick), 1);
        check("t1_x_e1",    32'(d_x), 0);
        check("t1_vclk_e1", 32'(d_vclk), 1);
        @(negedge clk);                           // after edge 2
        check("t1_tick_e2", 32'(d_tick), 0);
        check("t1_x_e2",    32'(d_x), 1);
        check("t1_vclk_e2", 32'(d_vclk), 0);
        check("t1_line_e2", 32'(d_line), 0);
        check("t1_s_vclk_e2", 32'(s_vclk), 1);
        @(negedge clk);                           // after edge 3
        check("t1_s_tick_e3", 32'(s_tick), 1);
        check("t1_s_x_e3",    32'(s_x), 0);
        @(negedge clk);                           // after edge 4
        check("t1_s_x_e4",    32'(s_x), 1);
        check("t1_s_vclk_e4", 32'(s_vclk), 0);
        check("t1_s_tick_e4", 32'(s_tick), 0);
        check("t1_s_frame_e4", 32'(s_frame), 0);

        // ---------------- T2 + T5: line timing and VGA_CLK phase ----------------
        px = 32'(d_x); pvclk = 32'(d_vclk); phs = 32'(d_hs); pblank = 32'(d_blank);
        step_err = 0; phase_err = 0; max_x = 0; hs_low = 0;
        hs_fall_x = -1; hs_rise_x = -1; blank_fall_x = -1;
        line_cnt = 0; last_line = -1; line_gap = -1; vclk_hi = 0;
        for (int i = 1; i <= 3210; i++) begin
            @(negedge clk);
            cx = 32'(d_x);
            if (cx != px) begin
                if (cx != ((px == 799) ? 0 : px + 1)) step_err++;
                if (!(pvclk == 1 && d_vclk == 1'b0)) phase_err++;
            end
            if (32'(d_vclk) == pvclk) phase_err++;
            if (d_vclk) vclk_hi++;
            if (cx > max_x) max_x = cx;
            if (!d_hs) hs_low++;
            if (phs == 1 && !d_hs) hs_fall_x = cx;
            if (phs == 0 && d_hs) hs_rise_x = cx;
            if (pblank == 1 && !d_blank) blank_fall_x = cx;
            if (d_line) begin
                line_cnt++;
                if (last_line >= 0) line_gap = i - last_line;
                last_line = i;
                if (cx != 0) step_err++;
            end
            px = cx; pvclk = 32'(d_vclk); phs = 32'(d_hs); pblank = 32'(d_blank);
        end
        check("t2_x_step",     32'(step_err), 0);
        check("t2_max_x",      32'(max_x), 799);
        check("t2_hs_low_clk", 32'(hs_low), 384);
        check("t2_hs_fall_x",  32'(hs_fall_x), 656);
        check("t2_hs_rise_x",  32'(hs_rise_x), 752);
        check("t2_blank_fall", 32'(blank_fall_x), 640);
        check("t2_line_cnt",   32'(line_cnt), 2);
        check("t2_line_gap",   32'(line_gap), 1600);
        check("t2_y_after",    32'(d_y), 2);
        check("t5_phase",      32'(phase_err), 0);
        check("t5_vclk_duty",  32'(vclk_hi), 1605);

        // ---------------- T3 + T4 + T5: frame timing on the small raster ----------------
        spx = 32'(s_x); spy = 32'(s_y); spblank = 32'(s_blank);
        spvclk = 32'(s_vclk); spframe = 32'(s_frame);
        dec_err = 0; s_step_err = 0; rng_err = 0; wrap_err = 0; s_phase_err = 0;
        fcnt = 0; last_f = -1; gap_f = -1; vs_acc = 0; vs_between = -1; s_vclk_hi = 0;
        for (int i = 1; i <= 1100; i++) begin
            @(negedge clk);
            sx = 32'(s_x); sy = 32'(s_y);
            exp_hs    = (sx >= 10 && sx <= 12) ? 1 : 0;
            exp_vs    = (sy == 5 || sy == 6) ? 1 : 0;
            exp_blank = (sx < 8 && sy < 4) ? 1 : 0;
            if (32'(s_hs) != exp_hs || 32'(s_vs) != exp_vs || 32'(s_blank) != exp_blank) dec_err++;
            if (sx > 14 || sy > 7) rng_err++;
            if (sx != spx) begin
                exp_x = (spx == 14) ? 0 : spx + 1;
                exp_y = (spx == 14) ? ((spy == 7) ? 0 : spy + 1) : spy;
                if (sx != exp_x || sy != exp_y) s_step_err++;
                if (!(spvclk == 1 && s_vclk == 1'b0)) s_phase_err++;
            end else if (sy != spy) begin
                s_step_err++;
            end
            if (s_vclk) s_vclk_hi++;
            if (s_frame) begin
                fcnt++;
                if (!s_line || spframe == 1) wrap_err++;
                if (sx != 0 || sy != 0 || spx != 14 || spy != 7) wrap_err++;
                if (spblank != 0 || s_blank != 1'b1) wrap_err++;
                if (last_f >= 0 && gap_f < 0) gap_f = i - last_f;
                last_f = i;
                if (fcnt == 2) vs_between = vs_acc;
                vs_acc = 0;
            end
            if (s_vs) vs_acc++;
            spx = sx; spy = sy; spblank = 32'(s_blank);
            spvclk = 32'(s_vclk); spframe = 32'(s_frame);
        end
        check("t3_decode",    32'(dec_err), 0);
        check("t3_step",      32'(s_step_err), 0);
        check("t3_range",     32'(rng_err), 0);
        check("t3_frame_cnt", 32'(fcnt), 2);
        check("t3_frame_gap", 32'(gap_f), 480);
        check("t3_vs_clks",   32'(vs_between), 120);
        check("t4_wrap",      32'(wrap_err), 0);
        check("t5_s_phase",   32'(s_phase_err), 0);
        check("t5_s_duty",    32'(s_vclk_hi), 550);

        // ---------------- T6: mid-frame asynchronous reset ----------------
        found = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (s_x == 10'd11 && s_y == 10'd5) begin
                found = 1;
                break;
            end
        end
        check("t6_reach_pos", 32'(found), 1);
        check("t6_pre_hs",    32'(s_hs), 1);
        check("t6_pre_vs",    32'(s_vs), 1);
        #2;
        rst_n = 1'b0;
        #1;                                       // still before the next rising edge
        check("t6_x",     32'(s_x), 0);
        check("t6_y",     32'(s_y), 0);
        check("t6_hs",    32'(s_hs), 0);
        check("t6_vs",    32'(s_vs), 0);
        check("t6_blank", 32'(s_blank), 1);
        check("t6_vclk",  32'(s_vclk), 0);
        check("t6_tick",  32'(s_tick), 0);
        check("t6_d_x",   32'(d_x), 0);
        check("t6_d_y",   32'(d_y), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        fs_early = 0; fs_late = 0; first_line = -1;
        for (int i = 1; i <= 500; i++) begin
            @(negedge clk);
            if (s_line && first_line < 0) first_line = i;
            if (s_frame) begin
                if (i <= 470) fs_early++;
                else fs_late++;
            end
        end
        check("t6_no_spurious_frame", 32'(fs_early), 0);
        check("t6_first_line",        32'(first_line), 60);
        check("t6_first_frame",       32'(fs_late), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
